// File: rtl/sram_block_responder.sv
// sram_block_responder: memory-side responder for the off-chip DE2 SRAM.
// Accepts single-word writes and block-fill reads, sequences the asynchronous
// 16-bit SRAM pins with a timed FSM and returns read words one per strobe.
// Optional build macro: SRAM_CWF_EN (critical-word-first read bursts).
module sram_block_responder #(
    parameter int ACCESS_CYCLES = 2,
    parameter int BLOCK_WORDS   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    input  logic                           req_we,
    input  logic [17:0]                    req_addr,
    input  logic [15:0]                    req_wdata,
    output logic                           req_ready,
    output logic                           resp_valid,
    output logic [15:0]                    resp_rdata,
    output logic [$clog2(BLOCK_WORDS)-1:0] resp_word_idx,
    inout  wire  [15:0]                    SRAM_DATA,
    output logic [17:0]                    SRAM_ADDRESS,
    output logic                           SRAM_UB_N_O,
    output logic                           SRAM_LB_N_O,
    output logic                           SRAM_WE_N_O,
    output logic                           SRAM_CE_N_O,
    output logic                           SRAM_OE_N_O
);
    localparam int IW = $clog2(BLOCK_WORDS);
    localparam int CW = $clog2(ACCESS_CYCLES);

    typedef enum logic [1:0] {IDLE, READ, WRITE, WHOLD} state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [IW-1:0]     idx, idx_d;
    logic [IW-1:0]     words, words_d;
    logic [17-IW:0]    base_hi, base_hi_d;
    logic [15:0]       wdata, wdata_d;
    logic              drive, drive_d;
    logic [17:0]       addr_d;
    logic              we_n_d, oe_n_d, ready_d, rvalid_d;
    logic [15:0]       rdata_d;
    logic [IW-1:0]     ridx_d;
    logic [IW-1:0]     start;

    // Byte lanes and chip enable are permanently active; the bus is tri-stated
    // whenever the write-drive register is clear.
    assign SRAM_UB_N_O = 1'b0;
    assign SRAM_LB_N_O = 1'b0;
    assign SRAM_CE_N_O = 1'b0;
    assign SRAM_DATA   = drive ? wdata : 16'bz;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state and next-register values for the access sequencer.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        idx_d     = idx;
        words_d   = words;
        base_hi_d = base_hi;
        wdata_d   = wdata;
        drive_d   = drive;
        addr_d    = SRAM_ADDRESS;
        we_n_d    = SRAM_WE_N_O;
        oe_n_d    = SRAM_OE_N_O;
        ready_d   = req_ready;
        rvalid_d  = 1'b0;
        rdata_d   = resp_rdata;
        ridx_d    = resp_word_idx;
        start     = '0;
`ifdef SRAM_CWF_EN
        start     = req_addr[IW-1:0];
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    if (req_we) begin
                        state_d = WRITE;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        drive_d = 1'b1;
                        we_n_d  = 1'b0;
                    end else begin
                        state_d   = READ;
                        base_hi_d = req_addr[17:IW];
                        idx_d     = start;
                        words_d   = '0;
                        addr_d    = {req_addr[17:IW], start};
                        oe_n_d    = 1'b0;
                    end
                end
            end
            READ: begin
                if (cnt == CW'(ACCESS_CYCLES - 1)) begin
                    // Word complete: capture it and step the offset within the block.
                    rvalid_d = 1'b1;
                    rdata_d  = SRAM_DATA;
                    ridx_d   = idx;
                    cnt_d    = '0;
                    idx_d    = idx + IW'(1);
                    words_d  = words + IW'(1);
                    addr_d   = {base_hi, idx_d};
                    if (words == IW'(BLOCK_WORDS - 1)) begin
                        state_d = IDLE;
                        oe_n_d  = 1'b1;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            WRITE: begin
                if (cnt == CW'(ACCESS_CYCLES - 2)) begin
                    state_d = WHOLD;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            WHOLD: begin
                // Address and data were held one cycle past WE_N rising; release now.
                state_d  = IDLE;
                drive_d  = 1'b0;
                rvalid_d = 1'b1;
                ridx_d   = '0;
                ready_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and sequencer bookkeeping.
    always_ff @(posedge clk) begin
        base_hi <= base_hi_d;
        wdata   <= wdata_d;
        if (rst) begin
            cnt           <= '0;
            idx           <= '0;
            words         <= '0;
            drive         <= 1'b0;
            SRAM_ADDRESS  <= '0;
            SRAM_WE_N_O   <= 1'b1;
            SRAM_OE_N_O   <= 1'b1;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_word_idx <= '0;
        end else begin
            cnt           <= cnt_d;
            idx           <= idx_d;
            words         <= words_d;
            drive         <= drive_d;
            SRAM_ADDRESS  <= addr_d;
            SRAM_WE_N_O   <= we_n_d;
            SRAM_OE_N_O   <= oe_n_d;
            req_ready     <= ready_d;
            resp_valid    <= rvalid_d;
            resp_rdata    <= rdata_d;
            resp_word_idx <= ridx_d;
        end
    end
endmodule
